// File: rtl/pwm_capture_if.sv
// PWM capture bus: sampled PWM line in, measurement results out.
// master drives the line and observes results; slave is the decoder.
interface pwm_capture_if;
    logic       pwm_in;
    logic [7:0] duty_seg;
    logic [8:0] period_seg;
    logic       valid;
    logic       stuck;

    modport master (
        output pwm_in,
        input  duty_seg,
        input  period_seg,
        input  valid,
        input  stuck
    );

    modport slave (
        input  pwm_in,
        output duty_seg,
        output period_seg,
        output valid,
        output stuck
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period in prescaler slots.
// Optional input glitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
    parameter logic [7:0] SEGMENT     = 8'd195,
    parameter logic [8:0] TIMEOUT_SEG = 9'd300
) (
    input logic          clk,
    input logic          rst,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    function automatic logic [8:0] sat_inc(input logic [8:0] v,
                                           input logic en);
        return (v == 9'h1FF || !en) ? v : v + 9'd1;
    endfunction

    logic s1_q, s2_q;
    logic rise, fall;

`ifdef PWM_CAP_FILTER_EN
    logic h1_q, h2_q, f_q, fd_q;

    // Synchronizer, 3-sample history, filtered level and its delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            h1_q <= 1'b0;
            h2_q <= 1'b0;
            f_q  <= 1'b0;
            fd_q <= 1'b0;
        end else begin
            s1_q <= bus.pwm_in;
            s2_q <= s1_q;
            h1_q <= s2_q;
            h2_q <= h1_q;
            if (s2_q && h1_q && h2_q)
                f_q <= 1'b1;
            else if (!s2_q && !h1_q && !h2_q)
                f_q <= 1'b0;
            fd_q <= f_q;
        end
    end

    assign rise = f_q & ~fd_q;
    assign fall = ~f_q & fd_q;
`else
    logic s3_q;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
`endif

    state_t     state_q;
    logic [7:0] c1_q;
    logic [8:0] hi_q, tot_q;
    logic [7:0] duty_q;
    logic [8:0] per_q;
    logic       valid_q, stuck_q;

    logic       tick, rnd, tmo;
    logic [8:0] hi_d, per_d;

    // Slot tick, half-slot rounding and timeout qualification.
    always_comb begin
        tick  = (c1_q == SEGMENT);
        rnd   = (c1_q > (SEGMENT >> 1));
        hi_d  = sat_inc(hi_q, rnd);
        per_d = sat_inc(tot_q, rnd);
        tmo   = (tot_q >= TIMEOUT_SEG) &&
                !(state_q == IDLE && stuck_q);
    end

    // Measurement FSM with prescaler and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c1_q    <= 8'd0;
            hi_q    <= 9'd0;
            tot_q   <= 9'd0;
            duty_q  <= 8'd0;
            per_q   <= 9'd0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            c1_q    <= (rise || tick) ? 8'd0 : c1_q + 8'd1;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HIGH;
                        hi_q    <= 9'd0;
                        tot_q   <= 9'd0;
                    end else if (tmo) begin
                        duty_q  <= s2_q ? 8'hFF : 8'h00;
                        per_q   <= 9'd0;
                        valid_q <= 1'b1;
                        stuck_q <= 1'b1;
                        tot_q   <= 9'd0;
                    end else begin
                        tot_q <= sat_inc(tot_q, tick);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_q <= LOW;
                        hi_q    <= hi_d;
                        tot_q   <= sat_inc(tot_q, tick);
                    end else if (tmo) begin
                        duty_q  <= s2_q ? 8'hFF : 8'h00;
                        per_q   <= 9'd0;
                        valid_q <= 1'b1;
                        stuck_q <= 1'b1;
                        state_q <= IDLE;
                        hi_q    <= 9'd0;
                        tot_q   <= 9'd0;
                    end else begin
                        hi_q  <= sat_inc(hi_q, tick);
                        tot_q <= sat_inc(tot_q, tick);
                    end
                end
                LOW: begin
                    if (rise) begin
                        duty_q  <= (hi_q > 9'd255) ? 8'hFF : hi_q[7:0];
                        per_q   <= per_d;
                        valid_q <= 1'b1;
                        stuck_q <= 1'b0;
                        state_q <= HIGH;
                        hi_q    <= 9'd0;
                        tot_q   <= 9'd0;
                    end else if (tmo) begin
                        duty_q  <= s2_q ? 8'hFF : 8'h00;
                        per_q   <= 9'd0;
                        valid_q <= 1'b1;
                        stuck_q <= 1'b1;
                        state_q <= IDLE;
                        hi_q    <= 9'd0;
                        tot_q   <= 9'd0;
                    end else begin
                        tot_q <= sat_inc(tot_q, tick);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.duty_seg   = duty_q;
    assign bus.period_seg = per_q;
    assign bus.valid      = valid_q;
    assign bus.stuck      = stuck_q;
endmodule
